// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: word width, instruction/address types and the
// {PC, instruction} pair carried from fetch to decode.
package mips_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] instr_t;
    typedef logic [XLEN-1:0] addr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } if_id_entry_t;

    // sll $0,$0,0
    localparam instr_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_entry_ram.sv
// DEPTH x 64-bit register array holding fetched {PC, instruction} pairs:
// one synchronous write port, one combinational read port.
module if_id_entry_ram
    import mips_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  if_id_entry_t     wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output if_id_entry_t     rdata_o
);

    if_id_entry_t mem_q [DEPTH];

    // NOTE: the array is tiny, so it is reset explicitly; no stale entry can
    // leak into simulation or silicon after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_skid_receiver.sv
// Fetch-to-decode queue replacing the bare IF/ID register: fetch stalls on
// back-pressure, branches flush, decode sees a NOP whenever the queue is empty.
module if_id_skid_receiver
    import mips_pkg::*;
#(
    parameter int     DEPTH     = 2,
    parameter instr_t NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         f_valid,
    output logic                         f_ready,
    input  logic [31:0]                  PC_F,
    input  logic [31:0]                  instruction_F,
    input  logic                         flush,
    input  logic                         d_ready,
    output logic                         d_valid,
    output logic [31:0]                  PC_D,
    output logic [31:0]                  PC_plus4_D,
    output logic [31:0]                  instruction_D,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [CW-1:0] count_q,  count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push, pop;
    if_id_entry_t  wr_entry, head;

    // f_ready looks only at stored state so fetch never sees a path from d_ready.
    assign f_ready = (count_q < FULL_COUNT);
    assign d_valid = (count_q != '0) && !flush;
    assign push    = f_valid && f_ready && !flush;
    assign pop     = d_valid && d_ready;

    assign wr_entry.pc    = PC_F;
    assign wr_entry.instr = instruction_F;

    if_id_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block can infer a latch.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only; blocking
    // stays inside the combinational next-state block above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign PC_D          = d_valid ? head.pc    : 32'h0;
    assign instruction_D = d_valid ? head.instr : NOP_INSTR;
    assign PC_plus4_D    = PC_D + 32'd4;
    assign occupancy     = count_q;

endmodule

// File: tb/tb_if_id_skid_receiver.sv
// Directed bench for if_id_skid_receiver: a queue scoreboard models the
// expected FIFO contents and every output is compared once per cycle.
module tb_if_id_skid_receiver;
    import mips_pkg::*;

    localparam int     DEPTH = 2;
    localparam instr_t NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_valid = 1'b0;
    logic        flush = 1'b0;
    logic        d_ready = 1'b0;
    logic [31:0] PC_F = '0;
    logic [31:0] instruction_F = '0;
    logic        f_ready;
    logic        d_valid;
    logic [31:0] PC_D;
    logic [31:0] PC_plus4_D;
    logic [31:0] instruction_D;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;
    if_id_entry_t sb[$];

    if_id_skid_receiver #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .f_valid       (f_valid),
        .f_ready       (f_ready),
        .PC_F          (PC_F),
        .instruction_F (instruction_F),
        .flush         (flush),
        .d_ready       (d_ready),
        .d_valid       (d_valid),
        .PC_D          (PC_D),
        .PC_plus4_D    (PC_plus4_D),
        .instruction_D (instruction_D),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h1234_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard's view of the queue.
    task automatic check_outputs(input string tag);
        logic        exp_dv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        exp_dv    = (sb.size() != 0) && !flush;
        exp_pc    = exp_dv ? sb[0].pc    : 32'h0;
        exp_instr = exp_dv ? sb[0].instr : NOP;
        check({tag, ".f_ready"},   {31'b0, f_ready},   {31'b0, (sb.size() < DEPTH)});
        check({tag, ".d_valid"},   {31'b0, d_valid},   {31'b0, exp_dv});
        check({tag, ".PC_D"},      PC_D,               exp_pc);
        check({tag, ".PC_plus4"},  PC_plus4_D,         exp_pc + 32'd4);
        check({tag, ".instr_D"},   instruction_D,      exp_instr);
        check({tag, ".occupancy"}, {30'b0, occupancy}, 32'(sb.size()));
    endtask

    // One clock cycle: drive, check, clock, then update the scoreboard.
    task automatic cycle(input string tag, input logic fv, input logic [31:0] pc,
                         input logic fl, input logic dr);
        logic exp_push, exp_pop;
        if_id_entry_t e;
        f_valid       = fv;
        PC_F          = pc;
        instruction_F = instr_of(pc);
        flush         = fl;
        d_ready       = dr;
        #1;
        check_outputs(tag);
        exp_push = fv && (sb.size() < DEPTH) && !fl;
        exp_pop  = (sb.size() != 0) && !fl && dr;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (exp_pop) void'(sb.pop_front());
            if (exp_push) begin
                e.pc    = pc;
                e.instr = instr_of(pc);
                sb.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        // 1: reset held and released with no stimulus
        #3;
        check_outputs("reset_held");
        #4 rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("reset_release");

        // 2: streaming, one word per cycle
        cycle("stream0", 1'b1, 32'h0, 1'b0, 1'b1);
        cycle("stream1", 1'b1, 32'h4, 1'b0, 1'b1);
        cycle("stream2", 1'b1, 32'h8, 1'b0, 1'b1);
        cycle("stream3", 1'b1, 32'hC, 1'b0, 1'b1);
        cycle("drain",   1'b0, 32'h0, 1'b0, 1'b1);

        // 3: back-pressure fills the queue, held word is ignored, then drains in order
        cycle("bp_push10", 1'b1, 32'h10, 1'b0, 1'b0);
        cycle("bp_push14", 1'b1, 32'h14, 1'b0, 1'b0);
        cycle("bp_full",   1'b1, 32'h18, 1'b0, 1'b0);
        cycle("bp_pop10",  1'b1, 32'h18, 1'b0, 1'b1);
        cycle("bp_pop14",  1'b1, 32'h18, 1'b0, 1'b1);
        cycle("bp_pop18",  1'b0, 32'h0,  1'b0, 1'b1);
        cycle("bp_empty",  1'b0, 32'h0,  1'b0, 1'b1);

        // 4: flush a full queue with an incoming word, then refill
        cycle("fl_fill20", 1'b1, 32'h20, 1'b0, 1'b0);
        cycle("fl_fill24", 1'b1, 32'h24, 1'b0, 1'b0);
        cycle("fl_flush",  1'b1, 32'h40, 1'b1, 1'b0);
        cycle("fl_push80", 1'b1, 32'h80, 1'b0, 1'b0);
        cycle("fl_see80",  1'b0, 32'h0,  1'b0, 1'b1);
        cycle("fl_empty",  1'b1, 32'h44, 1'b1, 1'b1);
        cycle("fl_still",  1'b0, 32'h0,  1'b0, 1'b1);

        // 5: PC + 4 wraps to zero
        cycle("wrap_push", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        cycle("wrap_see",  1'b0, 32'h0,         1'b0, 1'b1);

        // 6: asynchronous reset with a full queue and a word on the input
        cycle("ar_fill100", 1'b1, 32'h100, 1'b0, 1'b0);
        cycle("ar_fill104", 1'b1, 32'h104, 1'b0, 1'b0);
        f_valid       = 1'b1;
        PC_F          = 32'h108;
        instruction_F = instr_of(32'h108);
        #2 rst = 1'b0;
        #1;
        sb.delete();
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("reset_over_edge");
        rst = 1'b1;
        cycle("post_push200", 1'b1, 32'h200, 1'b0, 1'b1);
        cycle("post_see200",  1'b0, 32'h0,   1'b0, 1'b1);
        cycle("post_empty",   1'b0, 32'h0,   1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
